// File: rtl/pc_seq_ctrl_pkg.sv
// Shared configuration for the PC sequencer: state encodings and default
// reset PC / retired-counter width.
package pc_seq_ctrl_pkg;

  localparam int PSC_STATE_WIDTH = 3;

  typedef enum logic [PSC_STATE_WIDTH-1:0] {
    PSC_FETCH    = 3'd0,
    PSC_WAIT_RSP = 3'd1,
    PSC_EXEC     = 3'd2,
    PSC_HALT     = 3'd3,
    PSC_ERR      = 3'd4
  } psc_state_e;

  localparam logic [31:0] PSC_RESET_PC  = 32'h8000_0000;
  localparam int          PSC_CNT_WIDTH = 64;

endpackage

// File: rtl/pc_seq_ctrl_pc_reg.sv
// Parameterised register with write enable and synchronous active-low reset value.
// Latency: 1 cycle from w_en to q; no backpressure.
module pc_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)
      q <= RST_VAL;
    else if (w_en)
      q <= d;
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch/execute sequencer owning the architectural PC; min 3 cycles per instruction.
// Stalls in FETCH until ifu_req_ready, in WAIT_RSP until ifu_rsp_valid, in EXEC until exu_done.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int                   ISA_WIDTH  = 32,
  parameter int                   INST_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC   = ISA_WIDTH'(PSC_RESET_PC),
  parameter int                   CNT_WIDTH  = PSC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [ISA_WIDTH-1:0]  ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic [INST_WIDTH-1:0] ifu_rsp_data,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  exu_done,
  input  logic [ISA_WIDTH-1:0]  pc_in,
  input  logic                  pc_w_en,
  input  logic                  halt,
  output logic [ISA_WIDTH-1:0]  pc_out,
  output logic                  halted,
  output logic                  err_illegal,
  output logic                  err_misalign,
  output logic [CNT_WIDTH-1:0]  inst_cnt
);

  psc_state_e state, state_nxt;
  logic       pc_we, retire, inst_ld, set_halted, set_ill, set_mis;

  always_ff @(posedge clk) begin
    if (!rst)
      state <= PSC_FETCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_we      = 1'b0;
    retire     = 1'b0;
    inst_ld    = 1'b0;
    set_halted = 1'b0;
    set_ill    = 1'b0;
    set_mis    = 1'b0;
    case (state)
      PSC_FETCH: begin
        if (ifu_req_ready) state_nxt = PSC_WAIT_RSP;
      end
      PSC_WAIT_RSP: begin
        if (ifu_rsp_valid) begin
          inst_ld   = 1'b1;
          state_nxt = PSC_EXEC;
        end
      end
      PSC_EXEC: begin
        // Halt outranks illegal, which outranks misalignment.
        if (exu_done) begin
          if (halt) begin
            state_nxt  = PSC_HALT;
            set_halted = 1'b1;
            retire     = 1'b1;
          end else if (!pc_w_en) begin
            state_nxt  = PSC_ERR;
            set_halted = 1'b1;
            set_ill    = 1'b1;
          end else if (pc_in[1:0] != 2'b00) begin
            state_nxt  = PSC_ERR;
            set_halted = 1'b1;
            set_mis    = 1'b1;
          end else begin
            state_nxt = PSC_FETCH;
            pc_we     = 1'b1;
            retire    = 1'b1;
          end
        end
      end
      PSC_HALT, PSC_ERR: state_nxt = state;
      default: begin
        state_nxt  = PSC_ERR;
        set_halted = 1'b1;
      end
    endcase
  end

  assign ifu_req_valid = (state == PSC_FETCH);
  assign ifu_rsp_ready = (state == PSC_WAIT_RSP);
  assign inst_valid    = (state == PSC_EXEC);
  assign ifu_req_addr  = pc_out;

  pc_reg #(
    .WIDTH   (ISA_WIDTH),
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .w_en (pc_we),
    .d    (pc_in),
    .q    (pc_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      inst         <= '0;
      inst_cnt     <= '0;
      halted       <= 1'b0;
      err_illegal  <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      if (inst_ld)    inst         <= ifu_rsp_data;
      if (retire)     inst_cnt     <= inst_cnt + CNT_WIDTH'(1);
      if (set_halted) halted       <= 1'b1;
      if (set_ill)    err_illegal  <= 1'b1;
      if (set_mis)    err_misalign <= 1'b1;
    end
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Multi-cycle sequencer for the PC datapath; moves the core from single-cycle to fetch/execute operation.
- Owns the architectural PC register and drives the instruction-fetch request/response handshake toward the instruction memory.
- Presents the fetched instruction to decode/execute, then commits the next-PC value (pc_in, pc_w_en) produced by the PC-update logic.
- Detects halt (ebreak), illegal instructions (pc_w_en low at commit) and misaligned targets, and counts retired instructions.

Parameters:
- ISA_WIDTH, 32, width of PC and addresses.
- INST_WIDTH, 32, instruction word width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- CNT_WIDTH, 64, retired-instruction counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  memory accepts request.
- ifu_req_addr  out  ISA_WIDTH  fetch address; always equals pc_out.
- ifu_rsp_valid  in  1  instruction data valid.
- ifu_rsp_ready  out  1  controller accepts response.
- ifu_rsp_data  in  INST_WIDTH  fetched instruction.
- inst  out  INST_WIDTH  latched instruction to decode/execute.
- inst_valid  out  1  inst is valid and execute is in progress.
- exu_done  in  1  execute finished; pc_in, pc_w_en and halt are valid this cycle.
- pc_in  in  ISA_WIDTH  next PC from the PC-update logic.
- pc_w_en  in  1  next PC is legal; low means illegal instruction.
- halt  in  1  current instruction is ebreak.
- pc_out  out  ISA_WIDTH  architectural PC.
- halted  out  1  sticky; set in HALT or ERR.
- err_illegal  out  1  sticky; illegal instruction detected.
- err_misalign  out  1  sticky; pc_in[1:0] != 0 at commit.
- inst_cnt  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset: rst == 0 at a rising edge resets all state on that edge.
  - state = FETCH, pc_out = RESET_PC, inst = 0, inst_cnt = 0.
  - halted, err_illegal, err_misalign = 0.
  - All handshake outputs = 0 except ifu_req_valid.
- States: FETCH, WAIT_RSP, EXEC, HALT, ERR. Encoding is binary, 3 bits.
- Outputs are Moore (decoded from state only):
  - ifu_req_valid = 1 only in FETCH.
  - ifu_rsp_ready = 1 only in WAIT_RSP.
  - inst_valid = 1 only in EXEC.
- FETCH: ifu_req_valid and ifu_req_addr stay stable until ifu_req_ready. When ifu_req_valid & ifu_req_ready, go to WAIT_RSP.
- WAIT_RSP: when ifu_rsp_valid, latch inst = ifu_rsp_data and go to EXEC. ifu_rsp_valid in any other state is ignored and the data is dropped.
- EXEC: hold inst. On exu_done, evaluate in priority order:
  1. halt = 1: go to HALT, set halted, inst_cnt += 1, pc_out unchanged.
  2. pc_w_en = 0: go to ERR, set err_illegal and halted, no retire.
  3. pc_in[1:0] != 0: go to ERR, set err_misalign and halted, no retire, pc_out unchanged.
  4. Otherwise: pc_out = pc_in, inst_cnt += 1, go to FETCH.
- Without exu_done, EXEC waits indefinitely.
- HALT and ERR are absorbing; only reset leaves them.
- Latency: minimum 3 cycles per instruction (FETCH, WAIT_RSP, EXEC with exu_done in the first EXEC cycle) when ready and valid are both asserted.
- inst_cnt wraps modulo 2^CNT_WIDTH with no flag.
- pc_in is not clipped. Bit 0 masking (jalr) is done upstream; this block only checks alignment.
- Reset mid-transaction: any in-flight fetch is abandoned. A late response arrives in FETCH and is ignored because ifu_rsp_ready = 0.
- pc_out changes only at commit or reset.

Decomposition:
- Add to the shared config header:
  - state encodings PSC_FETCH, PSC_WAIT_RSP, PSC_EXEC, PSC_HALT, PSC_ERR
  - PSC_STATE_WIDTH = 3
  - RESET_PC default
  - CNT_WIDTH default
- One natural sub-module: pc_reg, a parameterised register with synchronous active-low reset value and write enable, used for pc_out.
- The FSM, the instruction latch and the counter stay inline.

Test Plan:
- Reset then always-ready memory returning 32'h00000013, exu_done=1 and pc_in=pc_out+4 every EXEC cycle -> pc_out sequence 8000_0000, 8000_0004, 8000_0008 every 3 cycles; inst_cnt=3 after 9 cycles.
- ifu_req_ready low for 5 cycles in FETCH -> ifu_req_valid held, ifu_req_addr stable at 8000_0000, no state change; ifu_rsp_valid pulsed during FETCH is ignored.
- exu_done with halt=1 at pc 8000_0010 -> HALT, halted=1, pc_out=8000_0010, inst_cnt incremented; no further ifu_req_valid for 20 cycles.
- exu_done with pc_w_en=0 -> ERR, err_illegal=1, inst_cnt unchanged.
- exu_done with pc_in=8000_0102 -> err_misalign=1, pc_out unchanged.
- rst low for 1 cycle while in WAIT_RSP, then a late ifu_rsp_valid -> state FETCH, pc_out=8000_0000, inst=0, late response dropped; inst_cnt preset near 2^64-1 via long run/force wraps to 0 on retire.
